// File: rtl/ldtu_gsel_buffer.sv
// Dual-gain lookahead buffer: picks x1 for a window opening LOOKAHEAD samples before an x10 saturation.
// Optional saturation-window statistics counter enabled by defining LDTU_GSEL_STATS_EN.
module ldtu_gsel_buffer #(
    parameter int unsigned NBITS     = 12,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PTR_W     = 4,
    parameter int unsigned LOOKAHEAD = 3,
    parameter int unsigned WIN_W     = 5,
    parameter int unsigned BASE_BITS = 6
) (
    input  logic               CLK,
    input  logic               rst_b,
    input  logic [1:0]         GAIN_SEL_MODE,
    input  logic [WIN_W-1:0]   WIN_LEN,
    input  logic [NBITS-1:0]   SATURATION_value,
    input  logic [1:0]         shift_gain_10,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   DATA_gain_01,
    input  logic [NBITS-1:0]   DATA_gain_10,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NBITS:0]     DATA_to_enc,
    output logic               baseline_flag,
    output logic [PTR_W:0]     fill,
    output logic [15:0]        sat_events
);

    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned HOLD_W = WIN_W + 1;

    logic [NBITS-1:0]  mem_x1  [DEPTH];
    logic [NBITS-1:0]  mem_x10 [DEPTH];
    logic [DEPTH-1:0]  mem_sat;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [NBITS-1:0]  sat_val;

    logic              push;
    logic              pop;
    logic              ahead_valid;
    logic [PTR_W-1:0]  ref_ptr;
    logic              ref_sat;
    logic [HOLD_W-1:0] win_base;
    logic [HOLD_W-1:0] win_eff;
    logic              sel_x1;

    // Handshake and lookahead reference, all derived from registered occupancy
    assign in_ready    = fill_q < FILL_W'(DEPTH);
    assign push        = in_valid & in_ready;
    assign ahead_valid = fill_q > FILL_W'(LOOKAHEAD);
    assign out_valid   = ahead_valid | (flush & (fill_q != '0));
    assign pop         = out_valid & out_ready;
    assign ref_ptr     = rd_ptr + PTR_W'(LOOKAHEAD);
    assign ref_sat     = ahead_valid & mem_sat[ref_ptr];
    assign fill        = fill_q;

    // Window never shorter than the lookahead span, so the saturated sample is always covered
    assign win_base = (HOLD_W'(WIN_LEN) > HOLD_W'(LOOKAHEAD + 1)) ? HOLD_W'(WIN_LEN)
                                                                  : HOLD_W'(LOOKAHEAD + 1);
    assign win_eff  = GAIN_SEL_MODE[0] ? (win_base << 1) : win_base;
    assign sel_x1   = GAIN_SEL_MODE[1] ? GAIN_SEL_MODE[0] : (ref_sat | (hold_cnt != '0));

    always_comb begin
        DATA_to_enc   = '0;
        baseline_flag = 1'b0;
        if (out_valid) begin
            DATA_to_enc = sel_x1 ? {1'b1, mem_x1[rd_ptr]} : {1'b0, mem_x10[rd_ptr]};
            if (GAIN_SEL_MODE[1] == 1'b0) begin
                baseline_flag = (DATA_to_enc[NBITS:BASE_BITS] == '0);
            end else begin
                baseline_flag = (DATA_to_enc[NBITS-1:BASE_BITS] == '0);
            end
        end
    end

    // Sample storage is intentionally not reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_x1[wr_ptr]  <= DATA_gain_01;
            mem_x10[wr_ptr] <= DATA_gain_10;
            mem_sat[wr_ptr] <= (DATA_gain_10 >= sat_val);
        end
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_q   <= '0;
            hold_cnt <= '0;
            sat_val  <= '1;
        end else begin
            sat_val <= SATURATION_value >> shift_gain_10;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
            if (GAIN_SEL_MODE[1]) begin
                hold_cnt <= '0;
            end else if (pop) begin
                if (ref_sat)              hold_cnt <= win_eff - HOLD_W'(1);
                else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

`ifdef LDTU_GSEL_STATS_EN
    logic [15:0] sat_cnt;

    // Counts windows opened from idle; reloads of an open window are not new events
    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            sat_cnt <= '0;
        end else if (pop && ref_sat && (hold_cnt == '0) && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign sat_events = sat_cnt;
`else
    assign sat_events = 16'h0000;
`endif

endmodule

// File: tb/tb_ldtu_gsel_buffer.sv
// Directed bench for ldtu_gsel_buffer: table-driven gain-window streams plus hand-written corner sequences.
module tb_ldtu_gsel_buffer;

    localparam int unsigned NBITS = 12;

    logic              CLK = 1'b0;
    logic              rst_b;
    logic [1:0]        GAIN_SEL_MODE;
    logic [4:0]        WIN_LEN;
    logic [NBITS-1:0]  SATURATION_value;
    logic [1:0]        shift_gain_10;
    logic              in_valid;
    logic              in_ready;
    logic [NBITS-1:0]  DATA_gain_01;
    logic [NBITS-1:0]  DATA_gain_10;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [NBITS:0]    DATA_to_enc;
    logic              baseline_flag;
    logic [4:0]        fill;
    logic [15:0]       sat_events;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ldtu_gsel_buffer dut (
        .CLK              (CLK),
        .rst_b            (rst_b),
        .GAIN_SEL_MODE    (GAIN_SEL_MODE),
        .WIN_LEN          (WIN_LEN),
        .SATURATION_value (SATURATION_value),
        .shift_gain_10    (shift_gain_10),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .DATA_gain_01     (DATA_gain_01),
        .DATA_gain_10     (DATA_gain_10),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .DATA_to_enc      (DATA_to_enc),
        .baseline_flag    (baseline_flag),
        .fill             (fill),
        .sat_events       (sat_events)
    );

    typedef struct {
        logic [1:0] mode;
        logic [4:0] win;
        int         s1;
        int         s2;
        int         n;
        int         lo;
        int         hi;
        int         ev;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Streams v.n samples at full rate, then flushes; checks every popped word
    task automatic run_stream(input int idx, input vec_t v);
        int pushed = 0;
        int popped = 0;
        int cyc    = 0;
        logic [15:0] ev0;
        logic [12:0] exp_w;
        @(posedge CLK); #1;
        GAIN_SEL_MODE    = 2'b10;
        in_valid         = 1'b0;
        flush            = 1'b0;
        out_ready        = 1'b0;
        WIN_LEN          = v.win;
        SATURATION_value = 12'h800;
        shift_gain_10    = 2'd0;
        @(posedge CLK); #1;
        GAIN_SEL_MODE = v.mode;
        ev0 = sat_events;
        while (popped < v.n && cyc < 200) begin
            @(posedge CLK); #1;
            in_valid     = (pushed < v.n);
            DATA_gain_10 = (pushed == v.s1 || pushed == v.s2) ? 12'h900 : 12'h100;
            DATA_gain_01 = 12'h200 + 12'(pushed);
            flush        = (pushed >= v.n);
            out_ready    = 1'b1;
            @(negedge CLK);
            if (out_valid) begin
                if (popped >= v.lo && popped <= v.hi)
                    exp_w = {1'b1, 12'h200 + 12'(popped)};
                else
                    exp_w = {1'b0, (popped == v.s1 || popped == v.s2) ? 12'h900 : 12'h100};
                chk($sformatf("v%0d_word%0d", idx, popped), 32'(DATA_to_enc), 32'(exp_w));
                popped++;
            end
            if (in_valid && in_ready) pushed++;
            cyc++;
        end
        chk($sformatf("v%0d_popcount", idx), 32'(popped), 32'(v.n));
        @(posedge CLK); #1;
        @(negedge CLK);
        chk($sformatf("v%0d_fill_end", idx), 32'(fill), 32'd0);
        chk($sformatf("v%0d_ov_end", idx), 32'(out_valid), 32'd0);
`ifdef LDTU_GSEL_STATS_EN
        if (v.ev >= 0) chk($sformatf("v%0d_sat_events", idx), 32'(sat_events - ev0), 32'(v.ev));
`endif
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    // Drains under flush; expects x10 words start, start+step, ...
    task automatic drain(input string name, input int exp_n, input logic [11:0] start, input int step);
        int got = 0;
        int cyc = 0;
        while (cyc < 40) begin
            @(posedge CLK); #1;
            in_valid  = 1'b0;
            flush     = 1'b1;
            out_ready = 1'b1;
            @(negedge CLK);
            if (!out_valid) break;
            chk($sformatf("%s_word%0d", name, got), 32'(DATA_to_enc),
                32'({1'b0, start + 12'(got * step)}));
            got++;
            cyc++;
        end
        chk($sformatf("%s_count", name), 32'(got), 32'(exp_n));
        chk($sformatf("%s_fill", name), 32'(fill), 32'd0);
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int popped;
        int pushed;

        vecs[0] = '{mode: 2'b00, win: 5'd8, s1: 6,  s2: 99, n: 24, lo: 3, hi: 10, ev: 1};
        vecs[1] = '{mode: 2'b01, win: 5'd8, s1: 6,  s2: 99, n: 24, lo: 3, hi: 18, ev: 1};
        vecs[2] = '{mode: 2'b10, win: 5'd8, s1: 6,  s2: 99, n: 12, lo: 1, hi: 0,  ev: -1};
        vecs[3] = '{mode: 2'b11, win: 5'd8, s1: 6,  s2: 99, n: 12, lo: 0, hi: 11, ev: -1};
        vecs[4] = '{mode: 2'b00, win: 5'd2, s1: 6,  s2: 99, n: 16, lo: 3, hi: 6,  ev: 1};
        vecs[5] = '{mode: 2'b00, win: 5'd4, s1: 6,  s2: 8,  n: 16, lo: 3, hi: 8,  ev: 1};
        vecs[6] = '{mode: 2'b00, win: 5'd8, s1: 3,  s2: 99, n: 16, lo: 0, hi: 7,  ev: 1};
        vecs[7] = '{mode: 2'b00, win: 5'd8, s1: 11, s2: 99, n: 12, lo: 8, hi: 11, ev: 1};

        rst_b            = 1'b0;
        GAIN_SEL_MODE    = 2'b10;
        WIN_LEN          = 5'd8;
        SATURATION_value = 12'h800;
        shift_gain_10    = 2'd0;
        in_valid         = 1'b0;
        DATA_gain_01     = '0;
        DATA_gain_10     = '0;
        flush            = 1'b0;
        out_ready        = 1'b0;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(DATA_to_enc), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_baseline", 32'(baseline_flag), 32'd0);
        chk("rst_sat_events", 32'(sat_events), 32'd0);
        repeat (2) @(negedge CLK);
        rst_b = 1'b1;

        // Forced x10: first word appears once LOOKAHEAD+1 entries are present
        popped = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge CLK); #1;
            in_valid     = (c < 10);
            DATA_gain_10 = 12'(c);
            DATA_gain_01 = 12'hABC;
            out_ready    = 1'b1;
            flush        = 1'b0;
            @(negedge CLK);
            if (c == 3) chk("m10_ov_fill3", 32'(out_valid), 32'd0);
            if (c == 4) chk("m10_ov_fill4", 32'(out_valid), 32'd1);
            if (out_valid) begin
                chk($sformatf("m10_word%0d", popped), 32'(DATA_to_enc), 32'(popped));
                popped++;
            end
        end
        chk("m10_popcount", 32'(popped), 32'd7);
        chk("m10_fill_left", 32'(fill), 32'd3);
        drain("m10_drain", 3, 12'd7, 1);

        for (int i = 0; i < 8; i++) run_stream(i, vecs[i]);

        // Full buffer back-pressure
        @(posedge CLK); #1;
        GAIN_SEL_MODE = 2'b10;
        pushed = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #1;
            in_valid     = 1'b1;
            DATA_gain_10 = 12'h100 + 12'(pushed);
            out_ready    = 1'b0;
            @(negedge CLK);
            if (in_ready) pushed++;
        end
        chk("full_pushed", 32'(pushed), 32'd16);
        chk("full_fill", 32'(fill), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drain("full_drain", 16, 12'h100, 1);

        // Short stream drained by flush
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            in_valid     = 1'b1;
            DATA_gain_10 = 12'h300 + 12'(c);
            out_ready    = 1'b0;
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("flush_fill5", 32'(fill), 32'd5);
        drain("flush_drain", 5, 12'h300, 1);
        chk("flush_ov", 32'(out_valid), 32'd0);

        // Baseline detection in gain-select and forced-x1 modes
        @(posedge CLK); #1;
        GAIN_SEL_MODE = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            in_valid     = 1'b1;
            DATA_gain_10 = (c == 0) ? 12'h03F : 12'h040;
            DATA_gain_01 = 12'h03F;
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("bl_m00_data", 32'(DATA_to_enc), 32'h03F);
        chk("bl_m00_flag1", 32'(baseline_flag), 32'd1);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        @(negedge CLK);
        chk("bl_m00_data2", 32'(DATA_to_enc), 32'h040);
        chk("bl_m00_flag0", 32'(baseline_flag), 32'd0);
        GAIN_SEL_MODE = 2'b11;
        #1;
        chk("bl_m11_data", 32'(DATA_to_enc), 32'h103F);
        chk("bl_m11_flag1", 32'(baseline_flag), 32'd1);
        GAIN_SEL_MODE = 2'b10;
        drain("bl_drain", 4, 12'h040, 0);

        // Asynchronous reset mid-stream
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            in_valid     = 1'b1;
            DATA_gain_10 = 12'h055;
        end
        @(posedge CLK); #2;
        in_valid = 1'b0;
        rst_b    = 1'b0;
        #1;
        chk("arst_fill", 32'(fill), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(DATA_to_enc), 32'd0);
        @(negedge CLK);
        rst_b = 1'b1;
        @(negedge CLK);
        chk("arst_fill_after", 32'(fill), 32'd0);
`ifndef LDTU_GSEL_STATS_EN
        chk("stats_tied_zero", 32'(sat_events), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
